// File: rtl/div_32bit_seq.sv
// div_32bit_seq
//   Multi-cycle restoring divider for the EX stage. One quotient bit per
//   cycle; signed operation divides magnitudes and fixes the signs at the end.
//   Quotient truncates toward zero; a nonzero remainder takes the dividend sign.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   signed_op  1 = two's-complement operands, sampled with start
//   dividend   numerator, sampled with start
//   divisor    denominator, sampled with start
//   busy       operation in progress (pipeline stalls)
//   done       one-cycle pulse; results valid from this cycle onward
//   quotient   registered quotient
//   remainder  registered remainder
//   div_zero   last completed operation had a zero divisor
//   ovf        last completed operation was most-negative / -1
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; zero-divisor and overflow resolve here
// CALC  | WIDTH shift/trial-subtract iterations
// FIX   | apply recorded signs, register results, pulse done

module div_32bit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;      // working dividend, fills with quotient bits
    logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic             is_zero, is_ovf;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             no_borrow;
    logic             trial_unused;

    assign dvd_neg = signed_op & dividend[WIDTH-1];
    assign dvs_neg = signed_op & divisor[WIDTH-1];
    assign dvd_abs = dvd_neg ? -dividend : dividend;
    assign dvs_abs = dvs_neg ? -divisor  : divisor;
    assign is_zero = (divisor == '0);
    assign is_ovf  = signed_op && (dividend == MOST_NEG) && (divisor == '1);

    // Shifted partial remainder needs one extra bit; the trial subtract adds
    // the inverted divisor plus one, and the carry out of the top bit means
    // no borrow (shifted >= divisor).
    assign shifted      = {rem_q, dvd_q[WIDTH-1]};
    assign trial        = {1'b0, shifted} + {2'b01, ~dvs_q} + (WIDTH+2)'(1);
    assign no_borrow    = trial[WIDTH+1];
    assign trial_unused = trial[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && !is_zero && !is_ovf) state_d = S_CALC;
            S_CALC: if (cnt_q == LAST_ITER) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_zero) begin
                        quo_d  = '1;
                        rmd_d  = dividend;
                        dz_d   = 1'b1;
                        ovf_d  = 1'b0;
                        done_d = 1'b1;
                    end else if (is_ovf) begin
                        quo_d  = dividend;
                        rmd_d  = '0;
                        dz_d   = 1'b0;
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        dvd_d   = dvd_abs;
                        dvs_d   = dvs_abs;
                        rem_d   = '0;
                        cnt_d   = '0;
                        q_neg_d = dvd_neg ^ dvs_neg;
                        r_neg_d = dvd_neg;
                    end
                end
            end
            S_CALC: begin
                rem_d = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q + CW'(1);
            end
            S_FIX: begin
                quo_d  = q_neg_q ? -dvd_q : dvd_q;
                rmd_d  = r_neg_q ? -rem_q : rem_q;
                dz_d   = 1'b0;
                ovf_d  = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = done_q;
        quotient  = quo_q;
        remainder = rmd_q;
        div_zero  = dz_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_div_32bit_seq.sv
module tb_div_32bit_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_zero, ovf;
    logic [W-1:0] quotient, remainder;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    div_32bit_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present a request for one edge; returns 1 ns after that edge.
    task automatic apply_start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges from the start edge until done, and the cycles busy was high.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset busy: got %b expected 0", busy); end
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset done: got %b expected 0", done); end
        vec_cnt++; if (quotient !== '0) begin err_cnt++; $display("FAIL reset quotient: got %h expected 0", quotient); end
        vec_cnt++; if (remainder !== '0) begin err_cnt++; $display("FAIL reset remainder: got %h expected 0", remainder); end
        vec_cnt++; if (div_zero !== 1'b0 || ovf !== 1'b0) begin err_cnt++; $display("FAIL reset flags: got dz=%b ovf=%b expected 0 0", div_zero, ovf); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_full_run(input string tag, input int idx, input vec_t tv);
        int lat, bcnt;
        apply_start(tv.s, tv.a, tv.b);
        wait_done(lat, bcnt);
        vec_cnt++; if (lat !== 33) begin err_cnt++; $display("FAIL %s[%0d] latency: got %0d expected 33", tag, idx, lat); end
        vec_cnt++; if (bcnt !== 33) begin err_cnt++; $display("FAIL %s[%0d] busy cycles: got %0d expected 33", tag, idx, bcnt); end
        vec_cnt++; if (quotient !== tv.q) begin err_cnt++; $display("FAIL %s[%0d] quotient: got %h expected %h", tag, idx, quotient, tv.q); end
        vec_cnt++; if (remainder !== tv.r) begin err_cnt++; $display("FAIL %s[%0d] remainder: got %h expected %h", tag, idx, remainder, tv.r); end
        vec_cnt++; if (div_zero !== 1'b0 || ovf !== 1'b0) begin err_cnt++; $display("FAIL %s[%0d] flags: got dz=%b ovf=%b expected 0 0", tag, idx, div_zero, ovf); end
        @(posedge clk); #1;
        vec_cnt++; if (done !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL %s[%0d] done pulse end: got done=%b busy=%b expected 0 0", tag, idx, done, busy); end
        vec_cnt++; if (quotient !== tv.q) begin err_cnt++; $display("FAIL %s[%0d] quotient hold: got %h expected %h", tag, idx, quotient, tv.q); end
    endtask

    task automatic test_unsigned;
        vec_t tbl [4];
        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        tbl[1] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1};
        tbl[3] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0};
        for (int i = 0; i < 4; i++) check_full_run("unsigned", i, tbl[i]);
    endtask

    task automatic test_signed;
        vec_t tbl [5];
        tbl[0] = '{1'b1, 32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2, 32'hFFFF_FFFE};
        tbl[1] = '{1'b1, 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2, 32'd2};
        tbl[2] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        32'hFFFF_FFFE};
        tbl[3] = '{1'b1, 32'd7,         32'h8000_0000,  32'd0,         32'd7};
        tbl[4] = '{1'b1, 32'h8000_0000, 32'd2,          32'hC000_0000, 32'd0};
        for (int i = 0; i < 5; i++) check_full_run("signed", i, tbl[i]);
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        for (int s = 0; s < 2; s++) begin
            apply_start(s[0], 32'h1234_5678, 32'd0);
            wait_done(lat, bcnt);
            vec_cnt++; if (lat !== 0 || bcnt !== 0) begin err_cnt++; $display("FAIL divzero[%0d] timing: got lat=%0d busy=%0d expected 0 0", s, lat, bcnt); end
            vec_cnt++; if (quotient !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL divzero[%0d] quotient: got %h expected ffffffff", s, quotient); end
            vec_cnt++; if (remainder !== 32'h1234_5678) begin err_cnt++; $display("FAIL divzero[%0d] remainder: got %h expected 12345678", s, remainder); end
            vec_cnt++; if (div_zero !== 1'b1 || ovf !== 1'b0) begin err_cnt++; $display("FAIL divzero[%0d] flags: got dz=%b ovf=%b expected 1 0", s, div_zero, ovf); end
            @(posedge clk); #1;
            vec_cnt++; if (done !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL divzero[%0d] after: got done=%b busy=%b expected 0 0", s, done, busy); end
        end
    endtask

    task automatic test_overflow;
        int lat, bcnt;
        apply_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        vec_cnt++; if (lat !== 0 || bcnt !== 0) begin err_cnt++; $display("FAIL ovf timing: got lat=%0d busy=%0d expected 0 0", lat, bcnt); end
        vec_cnt++; if (quotient !== 32'h8000_0000) begin err_cnt++; $display("FAIL ovf quotient: got %h expected 80000000", quotient); end
        vec_cnt++; if (remainder !== '0) begin err_cnt++; $display("FAIL ovf remainder: got %h expected 0", remainder); end
        vec_cnt++; if (ovf !== 1'b1 || div_zero !== 1'b0) begin err_cnt++; $display("FAIL ovf flags: got ovf=%b dz=%b expected 1 0", ovf, div_zero); end
        @(posedge clk); #1;
        vec_cnt++; if (done !== 1'b0 || ovf !== 1'b1) begin err_cnt++; $display("FAIL ovf after: got done=%b ovf=%b expected 0 1", done, ovf); end
    endtask

    task automatic test_start_ignored;
        int lat, bcnt;
        apply_start(1'b0, 32'd9, 32'd0);
        wait_done(lat, bcnt);
        apply_start(1'b0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        apply_start(1'b1, 32'd200, 32'd3);
        dividend = 32'hDEAD_BEEF; divisor = 32'd0; signed_op = 1'b1;
        vec_cnt++; if (quotient !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin err_cnt++; $display("FAIL ignore hold: got q=%h dz=%b expected ffffffff 1", quotient, div_zero); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL ignore busy: got %b expected 1", busy); end
        wait_done(lat, bcnt);
        vec_cnt++; if (lat !== 27) begin err_cnt++; $display("FAIL ignore latency: got %0d expected 27", lat); end
        vec_cnt++; if (quotient !== 32'd14 || remainder !== 32'd2) begin err_cnt++; $display("FAIL ignore result: got q=%h r=%h expected e 2", quotient, remainder); end
        vec_cnt++; if (div_zero !== 1'b0) begin err_cnt++; $display("FAIL ignore dz clear: got %b expected 0", div_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        apply_start(1'b0, 32'd100, 32'd7);
        wait_done(lat, bcnt);
        vec_cnt++; if (lat !== 33 || quotient !== 32'd14) begin err_cnt++; $display("FAIL b2b first: got lat=%0d q=%h expected 33 e", lat, quotient); end
        apply_start(1'b0, 32'hFFFF_FFFF, 32'h10);
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL b2b accept: got busy=%b expected 1", busy); end
        wait_done(lat, bcnt);
        vec_cnt++; if (lat !== 33) begin err_cnt++; $display("FAIL b2b latency: got %0d expected 33", lat); end
        vec_cnt++; if (quotient !== 32'h0FFF_FFFF || remainder !== 32'hF) begin err_cnt++; $display("FAIL b2b result: got q=%h r=%h expected 0fffffff f", quotient, remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat, bcnt;
        int seen;
        apply_start(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vec_cnt++; if (busy !== 1'b0 || done !== 1'b0) begin err_cnt++; $display("FAIL midrst ctrl: got busy=%b done=%b expected 0 0", busy, done); end
        vec_cnt++; if (quotient !== '0 || remainder !== '0) begin err_cnt++; $display("FAIL midrst outputs: got q=%h r=%h expected 0 0", quotient, remainder); end
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        vec_cnt++; if (seen !== 0) begin err_cnt++; $display("FAIL midrst no done: got %0d active cycles expected 0", seen); end
        apply_start(1'b0, 32'd50, 32'd5);
        wait_done(lat, bcnt);
        vec_cnt++; if (lat !== 33 || bcnt !== 33) begin err_cnt++; $display("FAIL midrst rerun timing: got lat=%0d busy=%0d expected 33 33", lat, bcnt); end
        vec_cnt++; if (quotient !== 32'd10 || remainder !== 32'd0) begin err_cnt++; $display("FAIL midrst rerun result: got q=%h r=%h expected a 0", quotient, remainder); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
